// File: rtl/sram_pkg.sv
// Shared sizing and word type for the serial SRAM digital top.
package sram_pkg;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned COLS   = 8;
  localparam int unsigned ADDR_W = $clog2(ROWS);
  typedef logic [COLS-1:0] word_t;
endpackage

// File: rtl/sram_if.sv
// Bundles the non-clock SRAM controls and read data; the tasks are zero-time
// drive helpers for benches and are never called from synthesizable logic.
interface sram_top_intf #(
  parameter int unsigned ROWS = sram_pkg::ROWS,
  parameter int unsigned COLS = sram_pkg::COLS
) (
  input logic clk
);
  localparam int unsigned AW = $clog2(ROWS);

  logic            serial_in;
  logic            shift;
  logic            load;
  logic            w_en;
  logic            r_en;
  logic [AW-1:0]   addr;
  logic            data_valid;
  logic [COLS-1:0] data_out;

  modport master (
    input  clk,
    output serial_in, shift, load, w_en, r_en, addr,
    input  data_valid, data_out
  );

  modport slave (
    input  serial_in, shift, load, w_en, r_en, addr,
    output data_valid, data_out
  );

  // Drive every control low.
  task automatic initialize();
    serial_in = 1'b0;
    shift     = 1'b0;
    load      = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    addr      = '0;
  endtask

  // Present one serial write bit for the next edge.
  task automatic serial_write(input logic b);
    shift     = 1'b1;
    serial_in = b;
  endtask

  // Request a read of word a at the next edge.
  task automatic read(input logic [AW-1:0] a);
    r_en = 1'b1;
    addr = a;
  endtask
endinterface

// File: rtl/sram_sipo.sv
// MSB-first serial-in/parallel-out assembly register for write data.
module sram_sipo
  import sram_pkg::*;
#(
  parameter int unsigned COLS = sram_pkg::COLS
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            shift,
  input  logic            serial_in,
  output logic [COLS-1:0] q
);
  logic [COLS-1:0] r_sreg;

  // Shift new bit in at the LSB; older bits move toward the MSB.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sreg <= '0;
    end else if (shift) begin
      r_sreg <= {r_sreg[COLS-2:0], serial_in};
    end
  end

  assign q = r_sreg;
endmodule

// File: rtl/serial_sram_top.sv
// Serial SRAM digital top: SIPO, write buffer, ROWSxCOLS array, read register.
module serial_sram_top
  import sram_pkg::*;
#(
  parameter int unsigned ROWS = sram_pkg::ROWS,
  parameter int unsigned COLS = sram_pkg::COLS
) (
  input logic        clk,
  input logic        arst_n,
  sram_top_intf.slave bus
);
  logic [COLS-1:0] w_sreg;
  logic [COLS-1:0] r_wbuf;
  logic [COLS-1:0] r_mem [ROWS];
  logic [COLS-1:0] r_data_out;
  logic            r_data_valid;

  sram_sipo #(.COLS(COLS)) u_sipo (
    .clk       (clk),
    .arst_n    (arst_n),
    .shift     (bus.shift),
    .serial_in (bus.serial_in),
    .q         (w_sreg)
  );

  // Stage the assembled word; takes the pre-edge SIPO contents.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wbuf <= '0;
    end else if (bus.load) begin
      r_wbuf <= w_sreg;
    end
  end

  // Storage array, fully cleared by reset; writes take the pre-edge buffer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.w_en) begin
      r_mem[bus.addr] <= r_wbuf;
    end
  end

  // Registered read; nonblocking update gives read-before-write on collision.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= bus.r_en;
      if (bus.r_en) begin
        r_data_out <= r_mem[bus.addr];
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
endmodule

// File: tb/tb_serial_sram_top.sv
// Randomized self-checking bench for serial_sram_top against a behavioural model.
module tb_serial_sram_top;
  localparam int unsigned ROWS = 16;
  localparam int unsigned COLS = 8;
  localparam int unsigned AW   = 4;

  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  sram_top_intf #(.ROWS(ROWS), .COLS(COLS)) bus (.clk(clk));

  serial_sram_top #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Reference model state
  logic [COLS-1:0] m_mem [ROWS];
  logic [COLS-1:0] m_sreg;
  logic [COLS-1:0] m_wbuf;
  logic [COLS-1:0] m_dout;
  logic            m_dv;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < ROWS; i++) m_mem[i] = '0;
    m_sreg = '0;
    m_wbuf = '0;
    m_dout = '0;
    m_dv   = 1'b0;
  endtask

  // Advance one clock with inputs already driven; update model, then compare.
  task automatic tick();
    logic            sh, ld, we, re, si;
    logic [AW-1:0]   a;
    logic [COLS-1:0] old_sreg, old_wbuf;
    sh = bus.shift; ld = bus.load; we = bus.w_en; re = bus.r_en;
    si = bus.serial_in; a = bus.addr;
    @(posedge clk);
    if (arst_n) begin
      old_sreg = m_sreg;
      old_wbuf = m_wbuf;
      if (re) begin
        m_dout = m_mem[a];
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (we) m_mem[a] = old_wbuf;
      if (ld) m_wbuf = old_sreg;
      if (sh) m_sreg = (old_sreg << 1) | COLS'(si);
    end
    @(negedge clk);
    check("dout", 32'(bus.data_out), 32'(m_dout));
    check("dv",   32'(bus.data_valid), 32'(m_dv));
    check("sreg", 32'(dut.w_sreg), 32'(m_sreg));
    check("wbuf", 32'(dut.r_wbuf), 32'(m_wbuf));
  endtask

  task automatic shift_word(input logic [COLS-1:0] w);
    for (int unsigned i = 0; i < COLS; i++) begin
      bus.initialize();
      bus.serial_write(w[COLS-1-i]);
      tick();
    end
    bus.initialize();
  endtask

  task automatic ser_write(input logic [COLS-1:0] w, input logic [AW-1:0] a);
    shift_word(w);
    bus.load = 1'b1;
    tick();
    bus.initialize();
    bus.w_en = 1'b1;
    bus.addr = a;
    tick();
    bus.initialize();
  endtask

  task automatic randomize_inputs();
    bus.shift     = 1'($urandom_range(0, 1));
    bus.load      = 1'($urandom_range(0, 1));
    bus.w_en      = 1'($urandom_range(0, 1));
    bus.r_en      = 1'($urandom_range(0, 1));
    bus.serial_in = 1'($urandom_range(0, 1));
    bus.addr      = AW'($urandom);
  endtask

  initial begin
    logic [COLS-1:0] exp_w;

    // Reset held 20 ns with random inputs
    bus.initialize();
    arst_n = 1'b0;
    model_reset();
    repeat (4) begin
      randomize_inputs();
      #5;
    end
    check("rst_dout", 32'(bus.data_out), 32'h0);
    check("rst_dv",   32'(bus.data_valid), 32'h0);
    bus.initialize();
    arst_n = 1'b1;
    for (int unsigned i = 0; i < ROWS; i++) begin
      bus.read(AW'(i));
      tick();
      check("rst_rd", 32'(bus.data_out), 32'h0);
    end
    bus.initialize();

    // Serial write of A5 to address 3
    ser_write(8'hA5, 4'd3);
    bus.read(4'd3);
    tick();
    check("a5_dout", 32'(bus.data_out), 32'hA5);
    check("a5_dv",   32'(bus.data_valid), 32'h1);
    bus.initialize();
    tick();
    check("a5_dv_pulse", 32'(bus.data_valid), 32'h0);
    bus.read(4'd4);
    tick();
    check("a5_other", 32'(bus.data_out), 32'h0);
    bus.initialize();

    // Full sweep then back-to-back reads
    for (int unsigned i = 0; i < ROWS; i++) ser_write(COLS'(i ^ 32'h5A), AW'(i));
    for (int unsigned i = 0; i < ROWS; i++) begin
      bus.read(AW'(i));
      tick();
      exp_w = COLS'(i ^ 32'h5A);
      check("sweep_dout", 32'(bus.data_out), 32'(exp_w));
      check("sweep_dv",   32'(bus.data_valid), 32'h1);
    end
    bus.initialize();

    // Same-cycle read and write on one address
    ser_write(8'h11, 4'd7);
    shift_word(8'h22);
    bus.load = 1'b1;
    tick();
    bus.initialize();
    bus.w_en = 1'b1;
    bus.read(4'd7);
    tick();
    check("rbw_old", 32'(bus.data_out), 32'h11);
    bus.initialize();
    bus.read(4'd7);
    tick();
    check("rbw_new", 32'(bus.data_out), 32'h22);
    bus.initialize();

    // Shift and load in the same cycle
    shift_word(8'hF0);
    bus.serial_write(1'b1);
    bus.load = 1'b1;
    tick();
    check("sl_wbuf", 32'(dut.r_wbuf), 32'hF0);
    check("sl_sreg", 32'(dut.w_sreg), 32'hE1);
    bus.initialize();

    // Random mix with an asynchronous reset mid-run
    for (int unsigned c = 0; c < 1000; c++) begin
      randomize_inputs();
      if (c == 500) begin
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check("arst_dout", 32'(bus.data_out), 32'h0);
        check("arst_dv",   32'(bus.data_valid), 32'h0);
        check("arst_sreg", 32'(dut.w_sreg), 32'h0);
        check("arst_wbuf", 32'(dut.r_wbuf), 32'h0);
        for (int unsigned i = 0; i < ROWS; i++) begin
          check("arst_mem", 32'(dut.r_mem[i]), 32'h0);
        end
        tick();
        arst_n = 1'b1;
        randomize_inputs();
      end
      tick();
    end
    bus.initialize();
    for (int unsigned i = 0; i < ROWS; i++) begin
      bus.read(AW'(i));
      tick();
      check("final_rd", 32'(bus.data_out), 32'(m_mem[i]));
    end
    bus.initialize();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
